// File: rtl/accum_heap_pkg.sv
// Shared types, default sizes and arithmetic helpers for the accum_heap_param slice.
package accum_heap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_LANES    = 64;
  localparam int DEF_DW       = 16;
  localparam int DEF_AW       = 16;
  localparam int DEF_LOOP_LEN = 3;

  // Sign-extend the low w bits of x to 64 bits (w <= 64).
  function automatic logic signed [63:0] sext(input logic [63:0] x, input int w);
    logic signed [63:0] t;
    t = $signed(x << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Signed add clamped to the range of a w-bit two's-complement value.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/accum_heap_param_lane.sv
// One accumulator lane: sign-extending adder and AW-bit register.
// With ACCUM_SATURATE_EN defined the lane clamps and keeps a sticky saturation bit.
module accum_lane
  import accum_heap_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
`ifdef ACCUM_SATURATE_EN
  output logic          o_sat,
`endif
  output logic [AW-1:0] o_acc
);

  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_next;

`ifdef ACCUM_SATURATE_EN
  logic signed [63:0] w_sum;
  logic signed [63:0] w_clamp;
  logic               r_sat;

  assign w_sum   = sext(64'(r_acc), AW) + sext(64'(i_data), DW);
  assign w_clamp = sat_add(sext(64'(r_acc), AW), sext(64'(i_data), DW), AW);
  assign w_next  = AW'(w_clamp);

  // Sticky until the accumulator itself is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            r_sat <= 1'b0;
    else if (i_clr)                      r_sat <= 1'b0;
    else if (i_en && (w_clamp != w_sum)) r_sat <= 1'b1;
  end

  assign o_sat = r_sat;
`else
  assign w_next = r_acc + AW'(sext(64'(i_data), DW));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= w_next;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/accum_heap_param.sv
// LANES-wide accumulator heap summing LOOP_LEN accepted beats, with valid/ready on both sides.
// Optional macro ACCUM_SATURATE_EN selects clamping arithmetic and adds the sat_flag port.
module accum_heap_param
  import accum_heap_pkg::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int LOOP_LEN = DEF_LOOP_LEN,
  parameter int CNT_W    = $clog2(LOOP_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                usr_rst,
  input  logic                halt,
  input  logic                in_v,
  output logic                in_rdy,
  input  logic [LANES*DW-1:0] in_data,
  output logic                out_v,
  input  logic                out_rdy,
  output logic [LANES*AW-1:0] out_data,
`ifdef ACCUM_SATURATE_EN
  output logic [LANES-1:0]    sat_flag,
`endif
  output logic [CNT_W-1:0]    beat_cnt,
  output logic                busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_out_v;
  logic             w_in_rdy;
  logic             w_accept;
  logic             w_last;
  logic             w_out_fire;
  logic             w_clr;

  assign w_in_rdy   = (r_state != HOLD) & ~halt & ~usr_rst;
  assign w_accept   = in_v & w_in_rdy;
  assign w_last     = w_accept && (r_beat_cnt == CNT_W'(LOOP_LEN - 1));
  assign w_out_fire = r_out_v & out_rdy;
  // usr_rst wins over a simultaneous output handshake; both simply clear.
  assign w_clr      = usr_rst | w_out_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (usr_rst) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = w_last ? HOLD : ACC;
        ACC:     if (w_last) w_state_nxt = HOLD;
        HOLD:    if (w_out_fire) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= '0;
      r_out_v    <= 1'b0;
    end else if (w_clr) begin
      r_beat_cnt <= '0;
      r_out_v    <= 1'b0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      r_out_v    <= w_last;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    accum_lane #(
      .DW(DW),
      .AW(AW)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_en  (w_accept),
      .i_data(in_data[i*DW +: DW]),
`ifdef ACCUM_SATURATE_EN
      .o_sat (sat_flag[i]),
`endif
      .o_acc (out_data[i*AW +: AW])
    );
  end

  assign in_rdy   = w_in_rdy;
  assign out_v    = r_out_v;
  assign beat_cnt = r_beat_cnt;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_accum_heap_param.sv
// Directed self-checking bench for accum_heap_param: a default instance plus a LOOP_LEN=1 instance.
// Expected overflow values follow ACCUM_SATURATE_EN when that macro is defined.
module tb_accum_heap_param;

  logic          clk;
  logic          rst;
  logic          usr_rst;
  logic          halt;
  logic          in_v;
  logic          in_rdy;
  logic [1023:0] in_data;
  logic          out_v;
  logic          out_rdy;
  logic [1023:0] out_data;
  logic [1:0]    beat_cnt;
  logic          busy;

  logic          d1_in_v;
  logic          d1_in_rdy;
  logic [31:0]   d1_in_data;
  logic          d1_out_v;
  logic          d1_out_rdy;
  logic [31:0]   d1_out_data;
  logic [0:0]    d1_beat_cnt;
  logic          d1_busy;

`ifdef ACCUM_SATURATE_EN
  logic [63:0]   sat_flag;
  logic [1:0]    d1_sat_flag;
`endif

  int checks = 0;
  int errors = 0;
  int acceptCount;

  accum_heap_param u_dut (
    .clk     (clk),
    .rst     (rst),
    .usr_rst (usr_rst),
    .halt    (halt),
    .in_v    (in_v),
    .in_rdy  (in_rdy),
    .in_data (in_data),
    .out_v   (out_v),
    .out_rdy (out_rdy),
    .out_data(out_data),
`ifdef ACCUM_SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .beat_cnt(beat_cnt),
    .busy    (busy)
  );

  accum_heap_param #(
    .LANES   (2),
    .LOOP_LEN(1)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .usr_rst (1'b0),
    .halt    (1'b0),
    .in_v    (d1_in_v),
    .in_rdy  (d1_in_rdy),
    .in_data (d1_in_data),
    .out_v   (d1_out_v),
    .out_rdy (d1_out_rdy),
    .out_data(d1_out_data),
`ifdef ACCUM_SATURATE_EN
    .sat_flag(d1_sat_flag),
`endif
    .beat_cnt(d1_beat_cnt),
    .busy    (d1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lane(input int i);
    return out_data[i*16 +: 16];
  endfunction

  // One beat offer: lane0 and lane63 get the given values, all other lanes zero.
  task automatic applyStimulus(input logic v, input logic [15:0] l0, input logic [15:0] l63);
    in_v            = v;
    in_data         = '0;
    in_data[15:0]   = l0;
    in_data[1023:1008] = l63;
    tick();
  endtask

  initial begin
    rst        = 1'b0;
    usr_rst    = 1'b0;
    halt       = 1'b0;
    out_rdy    = 1'b0;
    in_v       = 1'b1;
    in_data    = {64{16'h5A5A}};
    d1_in_v    = 1'b0;
    d1_in_data = '0;
    d1_out_rdy = 1'b0;

    repeat (3) tick();
    checkOutput("rst_out_v", 32'(out_v), 32'd0);
    checkOutput("rst_lane0", 32'(lane(0)), 32'd0);
    checkOutput("rst_lane63", 32'(lane(63)), 32'd0);
    checkOutput("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    in_v = 1'b0;
    rst  = 1'b1;
    tick();
    checkOutput("rel_in_rdy", 32'(in_rdy), 32'd1);
    checkOutput("rel_lane0", 32'(lane(0)), 32'd0);

    $display("[TB] basic loop");
    applyStimulus(1'b1, 16'h0001, 16'hFFFF);
    checkOutput("b1_beat_cnt", 32'(beat_cnt), 32'd1);
    checkOutput("b1_lane0", 32'(lane(0)), 32'h0001);
    checkOutput("b1_busy", 32'(busy), 32'd1);
    checkOutput("b1_out_v", 32'(out_v), 32'd0);
    applyStimulus(1'b1, 16'h0002, 16'hFFFF);
    checkOutput("b2_beat_cnt", 32'(beat_cnt), 32'd2);
    applyStimulus(1'b1, 16'h0003, 16'hFFFF);
    checkOutput("b3_out_v", 32'(out_v), 32'd1);
    checkOutput("b3_lane0", 32'(lane(0)), 32'h0006);
    checkOutput("b3_lane63", 32'(lane(63)), 32'hFFFD);
    checkOutput("b3_in_rdy", 32'(in_rdy), 32'd0);
    applyStimulus(1'b1, 16'h0100, 16'h0100);
    checkOutput("hold_no_accept", 32'(lane(0)), 32'h0006);
    in_v    = 1'b0;
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    checkOutput("hs_out_v", 32'(out_v), 32'd0);
    checkOutput("hs_lane0", 32'(lane(0)), 32'd0);
    checkOutput("hs_lane63", 32'(lane(63)), 32'd0);
    checkOutput("hs_beat_cnt", 32'(beat_cnt), 32'd0);
    checkOutput("hs_in_rdy", 32'(in_rdy), 32'd1);
    checkOutput("hs_busy", 32'(busy), 32'd0);

    $display("[TB] halt and backpressure");
    applyStimulus(1'b1, 16'h0005, 16'h0000);
    halt = 1'b1;
    in_data[15:0] = 16'h0007;
    repeat (4) tick();
    checkOutput("halt_in_rdy", 32'(in_rdy), 32'd0);
    checkOutput("halt_beat_cnt", 32'(beat_cnt), 32'd1);
    checkOutput("halt_lane0", 32'(lane(0)), 32'h0005);
    halt = 1'b0;
    applyStimulus(1'b1, 16'h0007, 16'h0000);
    checkOutput("halt_b2_lane0", 32'(lane(0)), 32'h000C);
    applyStimulus(1'b1, 16'h0001, 16'h0000);
    in_v = 1'b0;
    checkOutput("halt_b3_out_v", 32'(out_v), 32'd1);
    repeat (5) tick();
    checkOutput("bp_out_v", 32'(out_v), 32'd1);
    checkOutput("bp_lane0", 32'(lane(0)), 32'h000D);
    halt    = 1'b1;
    out_rdy = 1'b1;
    tick();
    halt    = 1'b0;
    out_rdy = 1'b0;
    checkOutput("halt_hs_out_v", 32'(out_v), 32'd0);
    checkOutput("halt_hs_lane0", 32'(lane(0)), 32'd0);

    $display("[TB] usr_rst");
    applyStimulus(1'b1, 16'h0010, 16'h0010);
    applyStimulus(1'b1, 16'h0010, 16'h0010);
    checkOutput("ur_pre_lane0", 32'(lane(0)), 32'h0020);
    in_v    = 1'b1;
    usr_rst = 1'b1;
    #1;
    checkOutput("ur_in_rdy", 32'(in_rdy), 32'd0);
    tick();
    usr_rst = 1'b0;
    in_v    = 1'b0;
    checkOutput("ur_lane0", 32'(lane(0)), 32'd0);
    checkOutput("ur_lane63", 32'(lane(63)), 32'd0);
    checkOutput("ur_beat_cnt", 32'(beat_cnt), 32'd0);
    checkOutput("ur_busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 16'h0010, 16'h0010);
    applyStimulus(1'b1, 16'h0010, 16'h0010);
    applyStimulus(1'b1, 16'h0010, 16'h0010);
    in_v = 1'b0;
    checkOutput("ur_fresh_lane0", 32'(lane(0)), 32'h0030);
    checkOutput("ur_fresh_out_v", 32'(out_v), 32'd1);
    usr_rst = 1'b1;
    out_rdy = 1'b1;
    tick();
    usr_rst = 1'b0;
    out_rdy = 1'b0;
    checkOutput("ur_hold_out_v", 32'(out_v), 32'd0);
    checkOutput("ur_hold_lane0", 32'(lane(0)), 32'd0);
    checkOutput("ur_hold_busy", 32'(busy), 32'd0);

    $display("[TB] overflow");
    applyStimulus(1'b1, 16'h7FFF, 16'h8000);
    applyStimulus(1'b1, 16'h0001, 16'hFFFF);
    applyStimulus(1'b1, 16'h0000, 16'h0000);
    in_v = 1'b0;
    checkOutput("ovf_out_v", 32'(out_v), 32'd1);
`ifdef ACCUM_SATURATE_EN
    checkOutput("ovf_lane0", 32'(lane(0)), 32'h7FFF);
    checkOutput("ovf_lane63", 32'(lane(63)), 32'h8000);
    checkOutput("ovf_sat", 32'(sat_flag), 32'h0000_0001 | (32'(sat_flag[63]) << 0));
    checkOutput("ovf_sat0", 32'(sat_flag[0]), 32'd1);
    checkOutput("ovf_sat63", 32'(sat_flag[63]), 32'd1);
    checkOutput("ovf_sat1", 32'(sat_flag[1]), 32'd0);
`else
    checkOutput("ovf_lane0", 32'(lane(0)), 32'h8000);
    checkOutput("ovf_lane63", 32'(lane(63)), 32'h7FFF);
`endif
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    checkOutput("ovf_hs_lane0", 32'(lane(0)), 32'd0);
`ifdef ACCUM_SATURATE_EN
    checkOutput("ovf_hs_sat0", 32'(sat_flag[0]), 32'd0);
`endif

    $display("[TB] LOOP_LEN=1 instance");
    d1_in_data = {16'h0000, 16'h1234};
    d1_in_v    = 1'b1;
    tick();
    checkOutput("l1_out_v", 32'(d1_out_v), 32'd1);
    checkOutput("l1_lane0", 32'(d1_out_data[15:0]), 32'h1234);
    checkOutput("l1_beat_cnt", 32'(d1_beat_cnt), 32'd1);
    checkOutput("l1_in_rdy", 32'(d1_in_rdy), 32'd0);
    d1_out_rdy  = 1'b1;
    acceptCount = 0;
    for (int i = 0; i < 10; i++) begin
      if (d1_in_rdy && d1_in_v) acceptCount++;
      tick();
    end
    checkOutput("l1_accept_rate", 32'(acceptCount), 32'd5);
    checkOutput("l1_rep_lane0", 32'(d1_out_data[15:0]), 32'h1234);
    d1_in_v    = 1'b0;
    d1_out_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
